// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV M-extension multiply/divide unit.
// Holds op/state enums, opcode constants and operand-signedness helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [2:0] {
    IDLE,
    MUL_ITER,
    DIV_ITER,
    FIXUP,
    DONE
  } state_e;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic logic a_signed(funct3_e f);
    return f inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  function automatic logic b_signed(funct3_e f);
    return f inside {F3_MULH, F3_DIV, F3_REM};
  endfunction

  function automatic logic is_sdiv(funct3_e f);
    return f inside {F3_DIV, F3_REM};
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative radix-2 multiply / restoring divide for RV32M/RV64M ops.
// One bit per cycle on magnitudes, sign fixed up in a final cycle.
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] neg_if(
    logic [WIDTH-1:0] x,
    logic             s
  );
    return s ? (~x + 1'b1) : x;
  endfunction

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  funct3_e          f3_q, f3_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] md_q, md_d;
  logic [WIDTH-1:0] res_q, res_d;

  funct3_e          f_in;
  logic             sa_in, sb_in;
  logic             dz_in, ov_in;
  logic [WIDTH-1:0] ma_in, mb_in;

  assign f_in  = funct3_e'(funct3);
  assign sa_in = a_signed(f_in) & op_a[WIDTH-1];
  assign sb_in = b_signed(f_in) & op_b[WIDTH-1];
  assign ma_in = neg_if(op_a, sa_in);
  assign mb_in = neg_if(op_b, sb_in);
  assign dz_in = (op_b == '0);
  assign ov_in = is_sdiv(f_in) && (op_a == MINV) && (op_b == '1);

  // Shift-add step: {hi,lo} shifts right one bit per cycle.
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   madd;

  assign addend = lo_q[0] ? md_q : '0;
  assign madd   = {1'b0, hi_q} + {1'b0, addend};

  // Restoring step: remainder in hi, dividend/quotient in lo.
  logic [WIDTH:0] shl;
  logic [WIDTH:0] diff;

  assign shl  = {hi_q, lo_q[WIDTH-1]};
  assign diff = shl - {1'b0, md_q};

  logic               sa_q, sb_q, neg_q;
  logic               dz_q, ov_q;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;
  logic [WIDTH-1:0]   fix_res;

  assign sa_q   = a_signed(f3_q) & a_q[WIDTH-1];
  assign sb_q   = b_signed(f3_q) & b_q[WIDTH-1];
  assign neg_q  = sa_q ^ sb_q;
  assign dz_q   = (b_q == '0);
  assign ov_q   = is_sdiv(f3_q) && (a_q == MINV) && (b_q == '1);
  assign prod   = {hi_q, lo_q};
  assign prod_s = neg_q ? (~prod + 1'b1) : prod;
  assign quo_s  = neg_if(lo_q, neg_q);
  assign rem_s  = neg_if(hi_q, sa_q);

  always_comb begin
    fix_res = '0;
    unique case (f3_q)
      F3_MUL:
        fix_res = prod_s[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:
        fix_res = prod_s[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:
        fix_res = dz_q ? '1 : (ov_q ? a_q : quo_s);
      F3_REM, F3_REMU:
        fix_res = dz_q ? a_q : (ov_q ? '0 : rem_s);
      default:
        fix_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    md_d    = md_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          f3_d  = f_in;
          a_d   = op_a;
          b_d   = op_b;
          cnt_d = '0;
          hi_d  = '0;
          if (!funct3[2]) begin
            state_d = MUL_ITER;
            lo_d    = mb_in;
            md_d    = ma_in;
          end else if (dz_in || ov_in) begin
            state_d = FIXUP;
          end else begin
            state_d = DIV_ITER;
            lo_d    = ma_in;
            md_d    = mb_in;
          end
        end
      end
      MUL_ITER: begin
        hi_d  = madd[WIDTH:1];
        lo_d  = {madd[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == LAST) state_d = FIXUP;
      end
      DIV_ITER: begin
        if (!diff[WIDTH]) begin
          hi_d = diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = shl[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == LAST) state_d = FIXUP;
      end
      FIXUP: begin
        res_d   = fix_res;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= F3_MUL;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      md_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      md_q    <= md_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q == MUL_ITER) || (state_q == DIV_ITER)
                || (state_q == FIXUP);
  assign done   = (state_q == DONE);
  assign result = res_q;

endmodule
